// File: rtl/monitor_pkg.sv
// rtl/monitor_pkg.sv - shared types and constants for the UART register monitor
//
// Contents:
//   state_t   : FSM state encoding for uart_reg_monitor
//   STS_*     : status byte codes returned at the end of every transaction
//   RW_BIT    : position of the read/write flag inside the CMD byte
//   sat_inc8  : saturating 8-bit increment used by the error counter
package monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_WR_DATA,
    ST_RD_SEND,
    ST_RD_WAIT,
    ST_RESP_SEND,
    ST_RESP_WAIT
  } state_t;

  localparam logic [7:0] STS_OK      = 8'h00;
  localparam logic [7:0] STS_BAD_ID  = 8'h01;
  localparam logic [7:0] STS_BAD_LEN = 8'h02;
  localparam logic [7:0] STS_RO      = 8'h03;
  localparam logic [7:0] STS_TIMEOUT = 8'h04;
  localparam logic [7:0] STS_RX_ERR  = 8'h05;

  localparam int RW_BIT = 7;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - NUM_REGS x REG_BYTES register storage with byte enables
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (loads RESET_VALUES)
//   i_we      : commit strobe; writes enabled bytes of register i_id
//   i_id      : target register index (only meaningful when i_we is high)
//   i_be      : per-byte write enable, bit b covers bits [8b +: 8]
//   i_wdata   : write data, little-endian byte order
//   o_regs    : flat register image, reg k at [k*REG_BYTES*8 +: REG_BYTES*8]
//   o_wr_stb  : one-hot copy of i_we decoded by i_id
module reg_bank
  import monitor_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int REG_BYTES = 4,
  parameter logic [NUM_REGS*REG_BYTES*8-1:0] RESET_VALUES = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_we,
  input  logic [$clog2(NUM_REGS)-1:0]     i_id,
  input  logic [REG_BYTES-1:0]            i_be,
  input  logic [REG_BYTES*8-1:0]          i_wdata,
  output logic [NUM_REGS*REG_BYTES*8-1:0] o_regs,
  output logic [NUM_REGS-1:0]             o_wr_stb
);

  localparam int ID_W = $clog2(NUM_REGS);

  logic [NUM_REGS*REG_BYTES*8-1:0] r_regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= RESET_VALUES;
    end else if (i_we) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        for (int b = 0; b < REG_BYTES; b++) begin
          if (i_id == ID_W'(k) && i_be[b]) begin
            r_regs[(k*REG_BYTES+b)*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    o_wr_stb = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      o_wr_stb[k] = i_we && (i_id == ID_W'(k));
    end
  end

  assign o_regs = r_regs;

endmodule

// File: rtl/uart_reg_monitor.sv
// rtl/uart_reg_monitor.sv - UART command monitor in front of a register bank
//
// Frame: CMD {rw[7], id[6:0]}, LEN, then LEN payload bytes for writes.
// Reads return LEN snapshot bytes; every transaction ends with one status byte.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   uart_rts / uart_cts : active-low flow control (cts low only while receiving)
//   rx_byte, rx_done    : received byte and its one-cycle valid pulse
//   rx_error            : one-cycle parity/framing error pulse
//   tx_write, tx_byte   : transmit start pulse and byte (held until next start)
//   tx_busy, tx_done    : transmitter busy level and completion pulse
//   regs                : flat register contents
//   reg_wr_stb          : one-hot strobe on the commit cycle
//   err_count           : saturating count of non-OK transactions
module uart_reg_monitor
  import monitor_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int REG_BYTES = 4,
  parameter logic [NUM_REGS*REG_BYTES*8-1:0] RESET_VALUES = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            uart_rts,
  output logic                            uart_cts,
  input  logic [7:0]                      rx_byte,
  input  logic                            rx_done,
  input  logic                            rx_error,
  output logic                            tx_write,
  output logic [7:0]                      tx_byte,
  input  logic                            tx_busy,
  input  logic                            tx_done,
  output logic [NUM_REGS*REG_BYTES*8-1:0] regs,
  output logic [NUM_REGS-1:0]             reg_wr_stb,
  output logic [7:0]                      err_count
);

  localparam int ID_W  = $clog2(NUM_REGS);
  localparam int IDX_W = $clog2(REG_BYTES+1);
  localparam int RW    = REG_BYTES*8;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES+1);

  state_t               r_state;
  logic                 r_cts;
  logic                 r_tx_write;
  logic [7:0]           r_tx_byte;
  logic [7:0]           r_status;
  logic [7:0]           r_err_count;
  logic                 r_resp_entry;
  logic                 r_cmd_rw;
  logic [6:0]           r_cmd_id;
  logic [IDX_W-1:0]     r_len;
  logic [IDX_W-1:0]     r_idx;
  logic [RW-1:0]        r_shadow;
  logic [REG_BYTES-1:0] r_be;
  logic [TMR_W-1:0]     r_timer;

  logic [NUM_REGS*RW-1:0] w_regs;
  logic [RW-1:0]          w_rd_word;
  logic [7:0]             w_tx_sel;
  logic [IDX_W-1:0]       w_idx_next;
  logic                   w_id_ok;
  logic                   w_ro;
  logic                   w_len_ok;
  logic                   w_timer_exp;
  logic                   w_last_done;
  logic                   w_commit;

  // Register selection uses the full 7-bit id so out-of-range ids read as 0
  // and never alias onto a real register.
  always_comb begin
    w_rd_word = '0;
    w_ro      = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_cmd_id == 7'(k)) begin
        w_rd_word = w_regs[k*RW +: RW];
        w_ro      = RO_MASK[k];
      end
    end
  end

  always_comb begin
    w_tx_sel = 8'h00;
    for (int b = 0; b < REG_BYTES; b++) begin
      if (r_idx == IDX_W'(b)) begin
        w_tx_sel = r_shadow[b*8 +: 8];
      end
    end
  end

  assign w_idx_next  = r_idx + IDX_W'(1);
  assign w_id_ok     = (32'(r_cmd_id) < NUM_REGS);
  assign w_len_ok    = (rx_byte != 8'h00) && (32'(rx_byte) <= REG_BYTES);
  assign w_timer_exp = (r_timer == TMR_W'(TIMEOUT_CYCLES-1));
  // All payload bytes stored: this cycle is the commit cycle. rx_error still
  // has priority so an error pulse here cancels the commit.
  assign w_last_done = (r_state == ST_WR_DATA) && (r_idx == r_len);
  assign w_commit    = w_last_done && !rx_error && w_id_ok && !w_ro;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cts        <= 1'b1;
      r_tx_write   <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_status     <= STS_OK;
      r_err_count  <= 8'h00;
      r_resp_entry <= 1'b0;
      r_cmd_rw     <= 1'b0;
      r_cmd_id     <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_be         <= '0;
      r_timer      <= '0;
    end else begin
      r_tx_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!uart_rts) begin
            r_state <= ST_CMD;
            r_cts   <= 1'b0;
            r_timer <= '0;
          end
        end

        ST_CMD, ST_LEN, ST_WR_DATA: begin
          if (rx_error) begin
            r_status     <= STS_RX_ERR;
            r_state      <= ST_RESP_SEND;
            r_cts        <= 1'b1;
            r_resp_entry <= 1'b1;
          end else if (w_last_done) begin
            r_status     <= !w_id_ok ? STS_BAD_ID : (w_ro ? STS_RO : STS_OK);
            r_state      <= ST_RESP_SEND;
            r_cts        <= 1'b1;
            r_resp_entry <= 1'b1;
          end else if (rx_done) begin
            r_timer <= '0;
            if (r_state == ST_CMD) begin
              r_cmd_rw <= rx_byte[RW_BIT];
              r_cmd_id <= rx_byte[6:0];
              r_state  <= ST_LEN;
            end else if (r_state == ST_LEN) begin
              r_len <= rx_byte[IDX_W-1:0];
              r_idx <= '0;
              if (!w_len_ok) begin
                r_status     <= STS_BAD_LEN;
                r_state      <= ST_RESP_SEND;
                r_cts        <= 1'b1;
                r_resp_entry <= 1'b1;
              end else if (r_cmd_rw) begin
                r_shadow <= '0;
                r_be     <= '0;
                r_state  <= ST_WR_DATA;
              end else begin
                // Snapshot now so later writes cannot alter bytes in flight.
                r_shadow <= w_rd_word;
                r_cts    <= 1'b1;
                if (w_id_ok) begin
                  r_status <= STS_OK;
                  r_state  <= ST_RD_SEND;
                end else begin
                  r_status     <= STS_BAD_ID;
                  r_state      <= ST_RESP_SEND;
                  r_resp_entry <= 1'b1;
                end
              end
            end else begin
              for (int b = 0; b < REG_BYTES; b++) begin
                if (r_idx == IDX_W'(b)) begin
                  r_shadow[b*8 +: 8] <= rx_byte;
                  r_be[b]            <= 1'b1;
                end
              end
              r_idx <= w_idx_next;
            end
          end else if (w_timer_exp) begin
            r_status     <= STS_TIMEOUT;
            r_state      <= ST_RESP_SEND;
            r_cts        <= 1'b1;
            r_resp_entry <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        ST_RD_SEND: begin
          if (!tx_busy) begin
            r_tx_write <= 1'b1;
            r_tx_byte  <= w_tx_sel;
            r_state    <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (tx_done) begin
            r_idx <= w_idx_next;
            if (w_idx_next == r_len) begin
              r_state      <= ST_RESP_SEND;
              r_resp_entry <= 1'b1;
            end else begin
              r_state <= ST_RD_SEND;
            end
          end
        end

        ST_RESP_SEND: begin
          if (r_resp_entry) begin
            r_resp_entry <= 1'b0;
            if (r_status != STS_OK) begin
              r_err_count <= sat_inc8(r_err_count);
            end
          end
          if (!tx_busy) begin
            r_tx_write <= 1'b1;
            r_tx_byte  <= r_status;
            r_state    <= ST_RESP_WAIT;
          end
        end

        ST_RESP_WAIT: begin
          if (tx_done) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cts   <= 1'b1;
        end
      endcase
    end
  end

  reg_bank #(
    .NUM_REGS    (NUM_REGS),
    .REG_BYTES   (REG_BYTES),
    .RESET_VALUES(RESET_VALUES)
  ) u_reg_bank (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_commit),
    .i_id    (r_cmd_id[ID_W-1:0]),
    .i_be    (r_be),
    .i_wdata (r_shadow),
    .o_regs  (w_regs),
    .o_wr_stb(reg_wr_stb)
  );

  assign regs      = w_regs;
  assign uart_cts  = r_cts;
  assign tx_write  = r_tx_write;
  assign tx_byte   = r_tx_byte;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_reg_monitor.sv
// tb/tb_uart_reg_monitor.sv - self-checking bench for uart_reg_monitor
module tb_uart_reg_monitor;

  localparam int NR = 8;
  localparam int RB = 4;
  localparam int TO = 64;
  localparam logic [255:0] RV = {32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h33333333, 32'hDEADBEEF, 32'hAABBCCDD, 32'h01234567};
  localparam logic [7:0] ROM = 8'b0000_1000;

  logic         clk = 1'b0;
  logic         reset;
  logic         rts;
  logic         cts;
  logic [7:0]   rx_byte;
  logic         rx_done;
  logic         rx_error;
  logic         tx_write;
  logic [7:0]   tx_byte;
  logic         tx_busy;
  logic         tx_done;
  logic [255:0] regs;
  logic [7:0]   reg_wr_stb;
  logic [7:0]   err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  int         stb_n;
  logic [7:0] stb_last;

  always #5 clk = ~clk;

  uart_reg_monitor #(
    .NUM_REGS(NR), .REG_BYTES(RB), .RESET_VALUES(RV), .RO_MASK(ROM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .uart_rts(rts), .uart_cts(cts),
    .rx_byte(rx_byte), .rx_done(rx_done), .rx_error(rx_error),
    .tx_write(tx_write), .tx_byte(tx_byte), .tx_busy(tx_busy), .tx_done(tx_done),
    .regs(regs), .reg_wr_stb(reg_wr_stb), .err_count(err_count)
  );

  // Transmitter model: busy for three cycles after each start, then a done pulse.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_write === 1'b1) begin
        tx_q.push_back(tx_byte);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    stb_n    = 0;
    stb_last = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (reg_wr_stb != 8'h00) begin
        stb_n++;
        stb_last = reg_wr_stb;
      end
    end
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_byte  = b;
    rx_done  = 1'b1;
    rx_error = err;
    @(negedge clk);
    rx_done  = 1'b0;
    rx_error = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_txn();
    tx_q.delete();
    stb_n    = 0;
    stb_last = 8'h00;
    @(negedge clk);
    rts = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c;
    c = 0;
    while (tx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    string      name;
    logic [7:0] cmd;
    logic [7:0] len;
    int         npay;
    logic [31:0] pay;
    int         ntx;
    logic [39:0] exp_tx;
    int         rid;
    logic [31:0] exp_reg;
    int         exp_stb_n;
    logic [7:0] exp_stb;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [7:0] cmd, input logic [7:0] len,
                              input int npay, input logic [31:0] pay, input int ntx,
                              input logic [39:0] etx, input int rid, input logic [31:0] ereg,
                              input int estbn, input logic [7:0] estb);
    vec_t v;
    v.name = nm; v.cmd = cmd; v.len = len; v.npay = npay; v.pay = pay; v.ntx = ntx;
    v.exp_tx = etx; v.rid = rid; v.exp_reg = ereg; v.exp_stb_n = estbn; v.exp_stb = estb;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = mk("full_wr",   8'h82, 8'd4, 4, 32'h44332211, 1, 40'h00,         2, 32'h44332211, 1, 8'h04);
    vecs[1] = mk("part_wr",   8'h81, 8'd2, 2, 32'h00000201, 1, 40'h00,         1, 32'hAABB0201, 1, 8'h02);
    vecs[2] = mk("rd_back",   8'h01, 8'd4, 0, 32'h0,        5, 40'h00AABB0201, 1, 32'hAABB0201, 0, 8'h00);
    vecs[3] = mk("bad_id_wr", 8'h89, 8'd1, 1, 32'h00000055, 1, 40'h01,         1, 32'hAABB0201, 0, 8'h00);
    vecs[4] = mk("len0",      8'h80, 8'd0, 0, 32'h0,        1, 40'h02,         0, 32'h01234567, 0, 8'h00);
    vecs[5] = mk("len5",      8'h80, 8'd5, 0, 32'h0,        1, 40'h02,         0, 32'h01234567, 0, 8'h00);
    vecs[6] = mk("ro_wr",     8'h83, 8'd4, 4, 32'hCAFEF00D, 1, 40'h03,         3, 32'h33333333, 0, 8'h00);
    vecs[7] = mk("bad_id_rd", 8'h0A, 8'd2, 0, 32'h0,        1, 40'h01,         0, 32'h01234567, 0, 8'h00);
    vecs[8] = mk("rd_len1",   8'h02, 8'd1, 0, 32'h0,        2, 40'h0011,       2, 32'h44332211, 0, 8'h00);
    vecs[9] = mk("wr_r7",     8'h87, 8'd1, 1, 32'h000000EE, 1, 40'h00,         7, 32'h000000EE, 1, 8'h80);

    reset    = 1'b1;
    rts      = 1'b1;
    rx_byte  = 8'h00;
    rx_done  = 1'b0;
    rx_error = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_regs", regs, RV);
    check("rst_cts", cts, 1'b1);
    check("rst_tx_write", tx_write, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_err", err_count, 8'h00);
    check("rst_stb", reg_wr_stb, 8'h00);

    for (int i = 0; i < 10; i++) begin
      start_txn();
      send_byte(vecs[i].cmd, 1'b0);
      send_byte(vecs[i].len, 1'b0);
      for (int p = 0; p < vecs[i].npay; p++) send_byte(vecs[i].pay[8*p +: 8], 1'b0);
      rts = 1'b1;
      wait_tx(vecs[i].ntx, 200);
      check($sformatf("%s_ntx", vecs[i].name), tx_q.size(), vecs[i].ntx);
      for (int j = 0; j < vecs[i].ntx && j < tx_q.size(); j++)
        check($sformatf("%s_tx%0d", vecs[i].name, j), tx_q[j], vecs[i].exp_tx[8*j +: 8]);
      check($sformatf("%s_reg", vecs[i].name), regs[vecs[i].rid*32 +: 32], vecs[i].exp_reg);
      check($sformatf("%s_stb_n", vecs[i].name), stb_n, vecs[i].exp_stb_n);
      check($sformatf("%s_stb", vecs[i].name), stb_last, vecs[i].exp_stb);
      check($sformatf("%s_cts", vecs[i].name), cts, 1'b1);
    end
    check("err_after_table", err_count, 8'd5);

    // Timeout mid-payload: two of four bytes, then silence.
    start_txn();
    send_byte(8'h80, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    check("to_cts_low", cts, 1'b0);
    rts = 1'b1;
    wait_tx(1, TO + 100);
    check("to_ntx", tx_q.size(), 1);
    if (tx_q.size() > 0) check("to_status", tx_q[0], 8'h04);
    check("to_reg0", regs[31:0], 32'h01234567);
    check("to_stb_n", stb_n, 0);
    check("to_cts", cts, 1'b1);

    // rx_error alone during payload.
    start_txn();
    send_byte(8'h81, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h77, 1'b0);
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    rts = 1'b1;
    wait_tx(1, 200);
    check("rxe_ntx", tx_q.size(), 1);
    if (tx_q.size() > 0) check("rxe_status", tx_q[0], 8'h05);
    check("rxe_reg1", regs[63:32], 32'hAABB0201);
    check("rxe_stb_n", stb_n, 0);

    // rx_error coincident with the final payload byte.
    start_txn();
    send_byte(8'h81, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'h98, 1'b1);
    rts = 1'b1;
    wait_tx(1, 200);
    check("rxe2_ntx", tx_q.size(), 1);
    if (tx_q.size() > 0) check("rxe2_status", tx_q[0], 8'h05);
    check("rxe2_reg1", regs[63:32], 32'hAABB0201);
    check("rxe2_stb_n", stb_n, 0);
    check("err_before_rst", err_count, 8'd8);

    // Reset while waiting for the first read byte to finish.
    start_txn();
    send_byte(8'h02, 1'b0);
    send_byte(8'h04, 1'b0);
    rts = 1'b1;
    begin
      int c;
      c = 0;
      while (tx_q.size() < 1 && c < 200) begin
        @(negedge clk);
        c++;
      end
    end
    check("rw_first_byte", tx_q.size(), 1);
    reset = 1'b1;
    #1;
    check("rw_rst_tx_write", tx_write, 1'b0);
    check("rw_rst_cts", cts, 1'b1);
    check("rw_rst_regs", regs, RV);
    check("rw_rst_err", err_count, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Back in IDLE: a fresh read of reg1 returns its reset value.
    start_txn();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    rts = 1'b1;
    wait_tx(5, 200);
    check("post_rst_ntx", tx_q.size(), 5);
    if (tx_q.size() == 5) begin
      check("post_rst_b0", tx_q[0], 8'hDD);
      check("post_rst_b1", tx_q[1], 8'hCC);
      check("post_rst_b2", tx_q[2], 8'hBB);
      check("post_rst_b3", tx_q[3], 8'hAA);
      check("post_rst_sts", tx_q[4], 8'h00);
    end
    check("post_rst_err", err_count, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
